// File: rtl/mix_scheduler_pkg.sv
// Shared types and defaults for the mixer sequencing / AGC controller.
package mix_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MIX = 2'd1,
    ST_AGC      = 2'd2
  } sched_state_t;

  localparam int unsigned SAMPLE_W      = 24;
  localparam int unsigned SHIFT_W       = 5;
  localparam logic [23:0] HI_THRESH_DEF = 24'h600000;
  localparam logic [23:0] LO_THRESH_DEF = 24'h100000;
  localparam logic [4:0]  SHIFT_MAX_DEF = 5'd31;

  // Magnitude of a signed sample; the most negative code saturates to full scale.
  function automatic logic [23:0] abs_sat(input logic signed [23:0] s);
    if (s == 24'sh800000) begin
      return 24'h7FFFFF;
    end else if (s < 0) begin
      return -s;
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/mix_scheduler_if.sv
// Handshake and data bundle between the scheduler and its environment.
interface mix_scheduler_if;
  logic               sample_valid_in;
  logic               agc_enable_in;
  logic [4:0]         manual_shift_in;
  logic               mix_valid_out;
  logic [4:0]         shift_out;
  logic               mix_done_in;
  logic signed [23:0] mixed_in;
  logic signed [23:0] sample_out;
  logic               sample_valid_out;
  logic               busy_out;
  logic [15:0]        overrun_count_out;
  logic               timeout_out;

  modport slave (
    input  sample_valid_in, agc_enable_in, manual_shift_in, mix_done_in, mixed_in,
    output mix_valid_out, shift_out, sample_out, sample_valid_out, busy_out,
           overrun_count_out, timeout_out
  );

  modport master (
    output sample_valid_in, agc_enable_in, manual_shift_in, mix_done_in, mixed_in,
    input  mix_valid_out, shift_out, sample_out, sample_valid_out, busy_out,
           overrun_count_out, timeout_out
  );
endinterface

// File: rtl/mix_scheduler_agc_tracker.sv
// Peak-tracking gain control: fast attack on loud samples, windowed release.
module agc_tracker
  import mix_scheduler_pkg::*;
#(
  parameter int unsigned PEAK_WINDOW = 4800,
  parameter logic [4:0]  SHIFT_INIT  = 5'd16,
  parameter logic [4:0]  SHIFT_MIN   = 5'd0,
  parameter logic [4:0]  SHIFT_MAX   = SHIFT_MAX_DEF,
  parameter logic [23:0] HI_THRESH   = HI_THRESH_DEF,
  parameter logic [23:0] LO_THRESH   = LO_THRESH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [4:0]  load_shift_i,
  input  logic        update_i,
  input  logic [23:0] mag_i,
  output logic [4:0]  shift_o
);

  localparam int unsigned WIN_W = (PEAK_WINDOW > 1) ? $clog2(PEAK_WINDOW) : 1;

  logic [4:0]        shift_q, shift_d;
  logic [23:0]       peak_q, peak_d, peak_new;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [5:0]        inc6;
  logic signed [5:0] dec6;

  always_comb begin
    shift_d  = shift_q;
    peak_d   = peak_q;
    win_d    = win_q;
    peak_new = (mag_i > peak_q) ? mag_i : peak_q;
    inc6     = {1'b0, shift_q} + 6'd1;
    dec6     = $signed({1'b0, shift_q}) - 6'sd1;
    if (load_i) begin
      shift_d = load_shift_i;
    end else if (update_i) begin
      if (mag_i >= HI_THRESH) begin
        shift_d = (inc6 > {1'b0, SHIFT_MAX}) ? SHIFT_MAX : inc6[4:0];
        peak_d  = '0;
        win_d   = '0;
      end else if (win_q == WIN_W'(PEAK_WINDOW - 1)) begin
        // The window's final peak includes the sample closing the window.
        if (peak_new < LO_THRESH) begin
          shift_d = (dec6 < $signed({1'b0, SHIFT_MIN})) ? SHIFT_MIN : dec6[4:0];
        end
        peak_d = '0;
        win_d  = '0;
      end else begin
        peak_d = peak_new;
        win_d  = win_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= SHIFT_INIT;
      peak_q  <= '0;
      win_q   <= '0;
    end else begin
      shift_q <= shift_d;
      peak_q  <= peak_d;
      win_q   <= win_d;
    end
  end

  assign shift_o = shift_q;

endmodule

// File: rtl/mix_scheduler.sv
// Launches one mixer pass per sample strobe, guards it with a timeout,
// forwards the result and runs the AGC between passes.
module mix_scheduler
  import mix_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned PEAK_WINDOW    = 4800,
  parameter logic [4:0]  SHIFT_INIT     = 5'd16,
  parameter logic [4:0]  SHIFT_MIN      = 5'd0,
  parameter logic [4:0]  SHIFT_MAX      = SHIFT_MAX_DEF,
  parameter logic [23:0] HI_THRESH      = HI_THRESH_DEF,
  parameter logic [23:0] LO_THRESH      = LO_THRESH_DEF
) (
  input logic            clk_in,
  input logic            rst_in,
  mix_scheduler_if.slave bus
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  sched_state_t       state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               mix_valid_q, mix_valid_d;
  logic signed [23:0] sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;
  logic [15:0]        overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic               timer_last;
  logic               busy;

  assign timer_last = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign busy       = (state_q != ST_IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (bus.sample_valid_in) state_d = ST_WAIT_MIX;
      ST_WAIT_MIX: begin
        if (bus.mix_done_in)  state_d = ST_AGC;
        else if (timer_last)  state_d = ST_IDLE;
      end
      ST_AGC:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_d        = timer_q;
    mix_valid_d    = 1'b0;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    timeout_d      = timeout_q;
    overrun_d      = overrun_q;
    if (bus.sample_valid_in && busy && (overrun_q != '1)) begin
      overrun_d = overrun_q + 16'd1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (bus.sample_valid_in) begin
          mix_valid_d = 1'b1;
          timer_d     = '0;
        end
      end
      ST_WAIT_MIX: begin
        timer_d = timer_q + 1'b1;
        if (bus.mix_done_in) begin
          sample_d       = bus.mixed_in;
          sample_valid_d = 1'b1;
        end else if (timer_last) begin
          timeout_d      = 1'b1;
          sample_d       = '0;
          sample_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      timer_q        <= '0;
      mix_valid_q    <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= '0;
      timeout_q      <= 1'b0;
    end else begin
      timer_q        <= timer_d;
      mix_valid_q    <= mix_valid_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      timeout_q      <= timeout_d;
    end
  end

  // Manual shift loads only in IDLE and AGC updates only in the AGC cycle,
  // so the shift seen by the mixer cannot move during a pass.
  agc_tracker #(
    .PEAK_WINDOW (PEAK_WINDOW),
    .SHIFT_INIT  (SHIFT_INIT),
    .SHIFT_MIN   (SHIFT_MIN),
    .SHIFT_MAX   (SHIFT_MAX),
    .HI_THRESH   (HI_THRESH),
    .LO_THRESH   (LO_THRESH)
  ) u_agc (
    .clk_i        (clk_in),
    .rst_i        (rst_in),
    .load_i       ((state_q == ST_IDLE) && !bus.agc_enable_in),
    .load_shift_i (bus.manual_shift_in),
    .update_i     ((state_q == ST_AGC) && bus.agc_enable_in),
    .mag_i        (abs_sat(sample_q)),
    .shift_o      (bus.shift_out)
  );

  assign bus.mix_valid_out     = mix_valid_q;
  assign bus.sample_out        = sample_q;
  assign bus.sample_valid_out  = sample_valid_q;
  assign bus.busy_out          = busy;
  assign bus.overrun_count_out = overrun_q;
  assign bus.timeout_out       = timeout_q;

endmodule

// File: tb/tb_mix_scheduler.sv
// Directed bench for mix_scheduler with a behavioural mixer model.
module tb_mix_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mix_scheduler_if b ();
  mix_scheduler_if b2 ();

  mix_scheduler u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (b)
  );

  mix_scheduler #(
    .TIMEOUT_CYCLES (16),
    .PEAK_WINDOW    (4),
    .SHIFT_INIT     (5'd2)
  ) u_dut2 (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (b2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mixer model: done a configurable number of cycles after each launch.
  int mix_lat    = 0;
  bit never_done = 1'b0;
  int stray_cnt  = 0;
  initial begin
    int done_cnt   = 0;
    int stray_seen = 0;
    b.mix_done_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      b.mix_done_in = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) b.mix_done_in = 1'b1;
      end
      if (stray_cnt != stray_seen) begin
        b.mix_done_in = 1'b1;
        stray_seen    = stray_cnt;
      end
      if (b.mix_valid_out && !never_done) begin
        if (mix_lat == 0) b.mix_done_in = 1'b1;
        else              done_cnt = mix_lat;
      end
    end
  end

  initial begin
    b2.mix_done_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      b2.mix_done_in = b2.mix_valid_out;
    end
  end

  int         launches   = 0;
  int         svalids    = 0;
  int         shift_viol = 0;
  logic       prev_busy  = 1'b0;
  logic [4:0] prev_shift = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (b.mix_valid_out)    launches++;
      if (b.sample_valid_out) svalids++;
      if (prev_busy && b.busy_out && (b.shift_out != prev_shift)) shift_viol++;
      prev_busy  = b.busy_out;
      prev_shift = b.shift_out;
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (b.busy_out && n < 400) begin
      step();
      n++;
    end
    if (b.busy_out) check_eq({tag, "_idle_bound"}, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string tag, inout int n);
    while (!b.sample_valid_out && n < 600) begin
      step();
      n++;
    end
    if (!b.sample_valid_out) check_eq({tag, "_valid_bound"}, 32'd0, 32'd1);
  endtask

  task automatic send(input string tag, input logic signed [23:0] v,
                      output logic signed [23:0] got, output int lat, output logic launch1);
    b.mixed_in        = v;
    b.sample_valid_in = 1'b1;
    step();
    b.sample_valid_in = 1'b0;
    launch1 = b.mix_valid_out;
    lat = 1;
    wait_valid(tag, lat);
    got = b.sample_out;
    wait_idle(tag);
  endtask

  task automatic send2();
    int n = 0;
    b2.sample_valid_in = 1'b1;
    step();
    b2.sample_valid_in = 1'b0;
    while (b2.busy_out && n < 50) begin
      step();
      n++;
    end
    if (b2.busy_out) check_eq("d2_idle_bound", 32'd0, 32'd1);
  endtask

  initial begin
    logic signed [23:0] got;
    int                 lat;
    logic               l1;
    int                 base;

    rst = 1'b1;
    b.sample_valid_in  = 1'b0;  b.agc_enable_in  = 1'b1;
    b.manual_shift_in  = 5'd0;  b.mixed_in       = '0;
    b2.sample_valid_in = 1'b0;  b2.agc_enable_in = 1'b1;
    b2.manual_shift_in = 5'd0;  b2.mixed_in      = 24'sh000010;
    repeat (3) step();
    rst = 1'b0;

    check_eq("rst_shift",     32'(b.shift_out), 32'd16);
    check_eq("rst_busy",      32'(b.busy_out), 32'd0);
    check_eq("rst_mix_valid", 32'(b.mix_valid_out), 32'd0);
    check_eq("rst_svalid",    32'(b.sample_valid_out), 32'd0);
    check_eq("rst_sample",    {8'd0, b.sample_out}, 32'd0);
    check_eq("rst_overrun",   32'(b.overrun_count_out), 32'd0);
    check_eq("rst_timeout",   32'(b.timeout_out), 32'd0);
    check_eq("d2_rst_shift",  32'(b2.shift_out), 32'd2);

    // Short-window instance: release every 4 quiet samples, clamped at 0.
    repeat (3) send2();
    check_eq("d2_win_partial", 32'(b2.shift_out), 32'd2);
    send2();
    check_eq("d2_win1", 32'(b2.shift_out), 32'd1);
    repeat (4) send2();
    check_eq("d2_win2", 32'(b2.shift_out), 32'd0);
    repeat (4) send2();
    check_eq("d2_win3_hold", 32'(b2.shift_out), 32'd0);

    // Basic pass with manual shift and 33-cycle mixer.
    b.agc_enable_in   = 1'b0;
    b.manual_shift_in = 5'd16;
    mix_lat = 33;
    step();
    base = launches;
    send("t1", 24'sh001234, got, lat, l1);
    check_eq("t1_launch_t1", 32'(l1), 32'd1);
    check_eq("t1_sample",    {8'd0, got}, 32'h001234);
    check_eq("t1_latency",   32'(lat), 32'd35);
    step();
    check_eq("t1_launch_cnt", 32'(launches - base), 32'd1);
    check_eq("t1_shift",      32'(b.shift_out), 32'd16);

    // Attack and the HI threshold boundary.
    b.agc_enable_in = 1'b1;
    mix_lat = 0;
    send("t2", -24'sd7000000, got, lat, l1);
    check_eq("t2_sample", {8'd0, got}, 32'h953040);
    check_eq("t2_attack", 32'(b.shift_out), 32'd17);
    send("t2b", 24'sh5FFFFF, got, lat, l1);
    check_eq("t2_below_hi", 32'(b.shift_out), 32'd17);
    send("t2c", 24'sh600000, got, lat, l1);
    check_eq("t2_at_hi", 32'(b.shift_out), 32'd18);

    // Release after a full quiet window.
    b.agc_enable_in   = 1'b0;
    b.manual_shift_in = 5'd16;
    repeat (2) step();
    check_eq("t3_manual", 32'(b.shift_out), 32'd16);
    b.agc_enable_in = 1'b1;
    for (int i = 0; i < 4799; i++) begin
      send("t3", (i % 2 == 0) ? 24'sh000800 : -24'sh000800, got, lat, l1);
    end
    check_eq("t3_pre_release", 32'(b.shift_out), 32'd16);
    send("t3", 24'sh000800, got, lat, l1);
    check_eq("t3_release", 32'(b.shift_out), 32'd15);

    // Done arriving in the final timeout cycle wins.
    mix_lat = 255;
    send("t4b", 24'sh000ABC, got, lat, l1);
    check_eq("t4b_sample",  {8'd0, got}, 32'h000ABC);
    check_eq("t4b_latency", 32'(lat), 32'd257);
    check_eq("t4b_timeout", 32'(b.timeout_out), 32'd0);

    // Two strobes dropped during one pass.
    mix_lat = 33;
    step();
    base = launches;
    b.mixed_in = 24'sh000055;
    b.sample_valid_in = 1'b1; step(); b.sample_valid_in = 1'b0;
    repeat (2) step();
    b.sample_valid_in = 1'b1; step(); b.sample_valid_in = 1'b0;
    step();
    b.sample_valid_in = 1'b1; step(); b.sample_valid_in = 1'b0;
    lat = 0;
    wait_valid("t4", lat);
    wait_idle("t4");
    step();
    check_eq("t4_overrun",   32'(b.overrun_count_out), 32'd2);
    check_eq("t4_launch_cnt", 32'(launches - base), 32'd1);

    // Timeout, stray done, then normal recovery.
    never_done = 1'b1;
    send("t5", 24'sh000777, got, lat, l1);
    check_eq("t5_sample",  {8'd0, got}, 32'd0);
    check_eq("t5_latency", 32'(lat), 32'd257);
    check_eq("t5_timeout", 32'(b.timeout_out), 32'd1);
    step();
    base = svalids;
    stray_cnt++;
    repeat (4) step();
    check_eq("t5_stray_svalid", 32'(svalids - base), 32'd0);
    check_eq("t5_stray_busy",   32'(b.busy_out), 32'd0);
    never_done = 1'b0;
    mix_lat = 0;
    send("t5r", 24'sh000321, got, lat, l1);
    check_eq("t5_recover",   {8'd0, got}, 32'h000321);
    check_eq("t5_sticky",    32'(b.timeout_out), 32'd1);

    // Overrun counter saturation.
    never_done = 1'b1;
    b.sample_valid_in = 1'b1;
    repeat (65800) step();
    b.sample_valid_in = 1'b0;
    wait_idle("t6");
    check_eq("t6_overrun_sat", 32'(b.overrun_count_out), 32'h0000FFFF);

    // Reset mid-pass, then manual shift in IDLE.
    never_done = 1'b0;
    mix_lat = 33;
    step();
    base = svalids;
    b.sample_valid_in = 1'b1; step(); b.sample_valid_in = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t7_busy",    32'(b.busy_out), 32'd0);
    check_eq("t7_shift",   32'(b.shift_out), 32'd16);
    check_eq("t7_svalid",  32'(b.sample_valid_out), 32'd0);
    check_eq("t7_overrun", 32'(b.overrun_count_out), 32'd0);
    check_eq("t7_timeout", 32'(b.timeout_out), 32'd0);
    repeat (40) step();
    check_eq("t7_no_sample", 32'(svalids - base), 32'd0);
    check_eq("t7_idle",      32'(b.busy_out), 32'd0);
    b.agc_enable_in   = 1'b0;
    b.manual_shift_in = 5'd9;
    repeat (2) step();
    check_eq("t7_manual9", 32'(b.shift_out), 32'd9);

    check_eq("shift_stable_busy", 32'(shift_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
